// File: rtl/mmc_resp_receiver.sv
// MMC boot response receiver: finds the CMD start bit, shifts in an R1/R3 (48-bit)
// or R2 (136-bit) frame, checks framing and CRC7 and returns index/argument fields.
module mmc_resp_receiver #(
  parameter int NCR_MAX = 32'sd64,
  parameter int CNT_W   = 32'sd8
) (
  input  logic        cclk,
  input  logic        rst_n,
  input  logic        sample_en,
  input  logic        arm,
  input  logic        abort,
  input  logic [1:0]  resp_type,
  input  logic        mmc_cmd_in,
  output logic        busy,
  output logic        resp_valid,
  output logic        resp_crc_err,
  output logic        resp_frame_err,
  output logic        resp_timeout,
  output logic [5:0]  resp_cmd_idx,
  output logic [31:0] resp_arg
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    SHIFT      = 2'd2,
    DONE       = 2'd3
  } state_e;

  localparam logic [1:0]       TYPE_R1     = 2'b00;
  localparam logic [1:0]       TYPE_R2     = 2'b01;
  localparam logic [1:0]       TYPE_R3     = 2'b10;
  localparam logic [1:0]       TYPE_RSVD   = 2'b11;
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(8'd1);
  localparam logic [CNT_W-1:0] TWO         = CNT_W'(8'd2);
  localparam logic [CNT_W-1:0] EIGHT       = CNT_W'(8'd8);
  localparam logic [CNT_W-1:0] LEN_R1      = CNT_W'(8'd48);
  localparam logic [CNT_W-1:0] LEN_R2      = CNT_W'(8'd136);
  localparam logic [CNT_W-1:0] IDX_R2_CRC  = CNT_W'(8'd127);
  localparam logic [CNT_W-1:0] IDX_CRC_END = CNT_W'(8'd8);
  localparam logic [CNT_W-1:0] NCR_C       = CNT_W'(NCR_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb_s;
    fb_s = crc[6] ^ bit_in;
    crc7_step = {crc[5:0], 1'b0} ^ (fb_s ? 7'h09 : 7'h00);
  endfunction

  state_e           state_q;
  logic [1:0]       type_q;
  logic [CNT_W-1:0] tocnt_q;
  logic [CNT_W-1:0] bitcnt_q;
  // Holds frame bits [45:0] of the most recent 46 samples; start and transmission
  // bits are tracked separately, so the top two frame bits never need storing.
  logic [45:0]      shift_q;
  logic [6:0]       crc_q;
  logic             tbit_q;
  logic [5:0]       hdr_idx_q;

  logic             is_r2_s;
  logic [CNT_W-1:0] frame_len_s;
  logic [CNT_W-1:0] bitnum_s;
  logic [CNT_W-1:0] bitidx_s;
  logic [CNT_W-1:0] tocnt_d;
  logic [CNT_W-1:0] bitcnt_d;
  logic [6:0]       crc_d;

  // Position of the arriving bit inside the frame and the CRC value it produces.
  always_comb begin
    is_r2_s     = (type_q == TYPE_R2);
    frame_len_s = is_r2_s ? LEN_R2 : LEN_R1;
    bitnum_s    = bitcnt_q + ONE;
    bitidx_s    = frame_len_s - bitnum_s;
    tocnt_d     = tocnt_q + ONE;
    bitcnt_d    = (bitcnt_q == CNT_MAX) ? bitcnt_q : bitnum_s;
    if (is_r2_s && (bitidx_s == IDX_R2_CRC)) begin
      crc_d = crc7_step(7'h00, mmc_cmd_in);
    end else if (bitidx_s >= IDX_CRC_END) begin
      crc_d = crc7_step(crc_q, mmc_cmd_in);
    end else begin
      crc_d = crc_q;
    end
  end

  // Receiver FSM with registered status pulses and held result fields.
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      type_q         <= TYPE_R1;
      tocnt_q        <= '0;
      bitcnt_q       <= '0;
      shift_q        <= 46'd0;
      crc_q          <= 7'h00;
      tbit_q         <= 1'b0;
      hdr_idx_q      <= 6'd0;
      busy           <= 1'b0;
      resp_valid     <= 1'b0;
      resp_crc_err   <= 1'b0;
      resp_frame_err <= 1'b0;
      resp_timeout   <= 1'b0;
      resp_cmd_idx   <= 6'd0;
      resp_arg       <= 32'd0;
    end else begin
      resp_valid   <= 1'b0;
      resp_timeout <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        busy    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (arm) begin
              type_q  <= (resp_type == TYPE_RSVD) ? TYPE_R1 : resp_type;
              tocnt_q <= '0;
              crc_q   <= 7'h00;
              busy    <= 1'b1;
              state_q <= WAIT_START;
            end
          end
          WAIT_START: begin
            if (sample_en) begin
              if (!mmc_cmd_in) begin
                bitcnt_q <= ONE;
                crc_q    <= crc7_step(7'h00, 1'b0);
                state_q  <= SHIFT;
              end else if (tocnt_d == NCR_C) begin
                tocnt_q      <= tocnt_d;
                resp_timeout <= 1'b1;
                busy         <= 1'b0;
                state_q      <= IDLE;
              end else begin
                tocnt_q <= tocnt_d;
              end
            end
          end
          SHIFT: begin
            if (sample_en) begin
              shift_q  <= {shift_q[44:0], mmc_cmd_in};
              bitcnt_q <= bitcnt_d;
              crc_q    <= crc_d;
              if (bitnum_s == TWO) begin
                tbit_q <= mmc_cmd_in;
              end
              if (is_r2_s && (bitnum_s == EIGHT)) begin
                hdr_idx_q <= {shift_q[4:0], mmc_cmd_in};
              end
              if (bitnum_s == frame_len_s) begin
                state_q <= DONE;
              end
            end
          end
          DONE: begin
            resp_cmd_idx   <= is_r2_s ? hdr_idx_q : shift_q[45:40];
            resp_arg       <= shift_q[39:8];
            resp_crc_err   <= (type_q != TYPE_R3) && (shift_q[7:1] != crc_q);
            resp_frame_err <= tbit_q | ~shift_q[0];
            resp_valid     <= 1'b1;
            busy           <= 1'b0;
            state_q        <= IDLE;
          end
          default: begin
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mmc_resp_receiver.sv
// Randomized bench for mmc_resp_receiver: frames are built and judged by a
// transaction-level model (CRC7 by polynomial division) and checked every cycle.
`timescale 1ns/1ps
module tb_mmc_resp_receiver;
  localparam int NCR = 64;
  localparam int INF = 32'h7fff_ffff;

  logic        cclk       = 1'b0;
  logic        rst_n      = 1'b0;
  logic        sample_en  = 1'b0;
  logic        arm        = 1'b0;
  logic        abort      = 1'b0;
  logic [1:0]  resp_type  = 2'b00;
  logic        mmc_cmd_in = 1'b1;
  logic        busy, resp_valid, resp_crc_err, resp_frame_err, resp_timeout;
  logic [5:0]  resp_cmd_idx;
  logic [31:0] resp_arg;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // model: busy interval, pulse cycles, pending and held result fields
  int m_busy_on, m_busy_off, m_valid_cyc, m_to_cyc;
  logic [5:0]  p_idx, h_idx;
  logic [31:0] p_arg, h_arg;
  logic        p_crc, h_crc, p_frm, h_frm;

  mmc_resp_receiver #(.NCR_MAX(NCR), .CNT_W(8)) dut (
    .cclk(cclk), .rst_n(rst_n), .sample_en(sample_en), .arm(arm), .abort(abort),
    .resp_type(resp_type), .mmc_cmd_in(mmc_cmd_in), .busy(busy),
    .resp_valid(resp_valid), .resp_crc_err(resp_crc_err),
    .resp_frame_err(resp_frame_err), .resp_timeout(resp_timeout),
    .resp_cmd_idx(resp_cmd_idx), .resp_arg(resp_arg)
  );

  always #5 cclk = ~cclk;
  always @(posedge cclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // remainder of msg(x)*x^7 divided by x^7+x^3+1; msg is the low n bits, MSB first
  function automatic logic [6:0] crc7_div(input logic [127:0] msg, input int n);
    logic [134:0] r;
    r = {msg, 7'd0};
    for (int i = n + 6; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] fr48(input logic [5:0] idx, input logic [31:0] a, input bit r3);
    logic [39:0] m;
    m = {2'b00, idx, a};
    return {m, (r3 ? 7'h7F : crc7_div({88'd0, m}, 40)), 1'b1};
  endfunction

  function automatic logic [135:0] fr136(input logic [119:0] pl);
    return {2'b00, 6'h3F, pl, crc7_div({8'd0, pl}, 120), 1'b1};
  endfunction

  function automatic bit exp_busy(input int n);
    return (n >= m_busy_on) && (n < m_busy_off);
  endfunction

  task automatic model_reset();
    m_busy_on = 0; m_busy_off = 0; m_valid_cyc = -1; m_to_cyc = -1;
    h_idx = 6'd0; h_arg = 32'd0; h_crc = 1'b0; h_frm = 1'b0;
    p_idx = 6'd0; p_arg = 32'd0; p_crc = 1'b0; p_frm = 1'b0;
  endtask

  task automatic expect_frame(input logic [135:0] f, input logic [1:0] ty);
    if (ty == 2'b01) begin
      p_idx = f[133:128];
      p_arg = f[39:8];
      p_crc = (f[7:1] != crc7_div({8'd0, f[127:8]}, 120));
      p_frm = f[134] | ~f[0];
    end else begin
      p_idx = f[45:40];
      p_arg = f[39:8];
      p_crc = (ty != 2'b10) && (f[7:1] != crc7_div({88'd0, f[47:8]}, 40));
      p_frm = f[46] | ~f[0];
    end
  endtask

  // every-cycle comparison of the DUT against the model
  always @(negedge cclk) begin
    if (chk_en) begin
      if (cyc == m_valid_cyc) begin
        h_idx = p_idx; h_arg = p_arg; h_crc = p_crc; h_frm = p_frm;
      end
      chk("busy", busy, exp_busy(cyc));
      chk("valid", resp_valid, (cyc == m_valid_cyc));
      chk("timeout", resp_timeout, (cyc == m_to_cyc));
      chk("cmd_idx", resp_cmd_idx, h_idx);
      chk("arg", resp_arg, h_arg);
      chk("crc_err", resp_crc_err, h_crc);
      chk("frame_err", resp_frame_err, h_frm);
    end
  end

  task automatic tick();
    @(posedge cclk); #1;
  endtask

  task automatic idle_gap();
    repeat (3) tick();
  endtask

  task automatic samp(input logic b);
    int gap;
    gap = $urandom_range(0, 3);
    repeat (gap) tick();
    mmc_cmd_in = b; sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic do_arm(input logic [1:0] ty);
    arm = 1'b1; resp_type = ty;
    tick();
    arm = 1'b0;
    if (!exp_busy(cyc - 1)) begin m_busy_on = cyc; m_busy_off = INF; end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    if (exp_busy(cyc - 1)) m_busy_off = cyc;
    if (m_valid_cyc > cyc) m_valid_cyc = -1;
  endtask

  task automatic send_resp(input logic [1:0] ty, input logic [135:0] f, input int n_idle,
                           input int abort_at, input int arm_at);
    int len;
    len = (ty == 2'b01) ? 136 : 48;
    do_arm(ty);
    for (int i = 0; i < n_idle; i++) begin
      samp(1'b1);
      if (i + 1 == NCR) begin
        m_to_cyc = cyc; m_busy_off = cyc;
        idle_gap();
        return;
      end
    end
    for (int k = 0; k < len; k++) begin
      if (k == abort_at) begin do_abort(); idle_gap(); return; end
      if (k == arm_at) do_arm(2'b01);
      samp(f[len-1-k]);
    end
    m_valid_cyc = cyc + 1; m_busy_off = cyc + 1;
    expect_frame(f, ty);
    idle_gap();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0]  f48, g48;
    logic [135:0] f136, g136;
    logic [127:0] rnd;
    logic [119:0] pl;
    logic [1:0]   ty;
    int           len, nidle, ab, j;

    model_reset();
    repeat (3) tick();
    chk("reset_busy", busy, 64'd0);
    chk("reset_valid", resp_valid, 64'd0);
    chk("reset_arg", resp_arg, 64'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // model pins against known CRC7 values
    chk("crc_cmd0", crc7_div({88'd0, 40'h40_0000_0000}, 40), 64'h4A);
    chk("crc_cmd17", crc7_div({88'd0, 40'h51_0000_0000}, 40), 64'h2A);
    f48 = fr48(6'h11, 32'h0000_0900, 1'b0);
    chk("crc_r1_ex", f48[7:1], 64'h33);

    // R3 OCR ready
    send_resp(2'b10, {88'd0, 48'h3F80FF8000FF}, 3, -1, -1);
    chk("t2_arg", resp_arg, 64'h80FF8000);
    chk("t2_idx", resp_cmd_idx, 64'h3F);
    chk("t2_crc", resp_crc_err, 64'd0);
    chk("t2_frm", resp_frame_err, 64'd0);

    // R1 CMD3, then the same frame with argument bit 16 flipped
    f48 = fr48(6'h03, 32'h0001_0000, 1'b0);
    send_resp(2'b00, {88'd0, f48}, 2, -1, -1);
    chk("t3_crc_ok", resp_crc_err, 64'd0);
    g48 = f48; g48[24] = ~g48[24];
    send_resp(2'b00, {88'd0, g48}, 1, -1, -1);
    chk("t3_crc_bad", resp_crc_err, 64'd1);
    chk("t3_arg", resp_arg, 64'h0000_0000);

    // reset asserted mid-SHIFT clears everything at once
    do_arm(2'b00);
    for (int k = 0; k < 20; k++) samp(f48[47-k]);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t1_busy", busy, 64'd0);
    chk("t1_valid", resp_valid, 64'd0);
    chk("t1_to", resp_timeout, 64'd0);
    chk("t1_idx", resp_cmd_idx, 64'd0);
    chk("t1_arg", resp_arg, 64'd0);
    chk("t1_crc", resp_crc_err, 64'd0);
    chk("t1_frm", resp_frame_err, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;
    for (int k = 20; k < 48; k++) samp(f48[47-k]);
    idle_gap();

    // timeout on the 64th high sample; start on the 63rd is accepted
    send_resp(2'b00, 136'd0, NCR, -1, -1);
    chk("t4_busy", busy, 64'd0);
    f48 = fr48(6'h11, 32'h0000_0900, 1'b0);
    send_resp(2'b00, {88'd0, f48}, NCR - 2, -1, -1);
    chk("t4_arg", resp_arg, 64'h0000_0900);

    // R2 CID, then the same frame with end bit cleared
    rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
    pl = rnd[119:0];
    f136 = fr136(pl);
    send_resp(2'b01, f136, 4, -1, -1);
    chk("t5_arg", resp_arg, pl[31:0]);
    chk("t5_crc", resp_crc_err, 64'd0);
    chk("t5_idx", resp_cmd_idx, 64'h3F);
    g136 = f136; g136[0] = 1'b0;
    send_resp(2'b01, g136, 0, -1, -1);
    chk("t5_frm", resp_frame_err, 64'd1);

    // arm+abort in IDLE, arm during SHIFT, abort at bit 20
    arm = 1'b1; abort = 1'b1; resp_type = 2'b00;
    tick();
    arm = 1'b0; abort = 1'b0;
    tick();
    chk("t6_idle", busy, 64'd0);
    f48 = fr48(6'h2A, 32'hDEAD_BEEF, 1'b0);
    send_resp(2'b00, {88'd0, f48}, 2, -1, 10);
    chk("t6_arg", resp_arg, 64'hDEAD_BEEF);
    send_resp(2'b00, {88'd0, fr48(6'h15, 32'h1234_5678, 1'b0)}, 1, 20, -1);
    chk("t6_hold", resp_arg, 64'hDEAD_BEEF);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      ty = 2'($urandom_range(0, 3));
      len = (ty == 2'b01) ? 136 : 48;
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (ty == 2'b01) f136 = fr136(rnd[119:0]);
      else f136 = {88'd0, fr48(rnd[5:0], rnd[37:6], ty == 2'b10)};
      case ($urandom_range(0, 5))
        0: begin j = $urandom_range(0, len - 2); f136[j] = ~f136[j]; end
        1: f136[0] = 1'b0;
        default: ;
      endcase
      nidle = ($urandom_range(0, 9) == 0) ? NCR : $urandom_range(0, 10);
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len - 1) : -1;
      send_resp(ty, f136, nidle, ab, -1);
    end

    idle_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
